multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width; shift amount = low $clog2(DATA_WIDTH) bits of alu_in_2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 alu_op  input  4  operation code per `alu_func.v` FUNC_* encodings.
REQ-007 alu_in_1  input  DATA_WIDTH  operand A.
REQ-008 alu_in_2  input  DATA_WIDTH  operand B / shift amount.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 alu_result  output  DATA_WIDTH  computed result.
REQ-012 alu_bcond  output  1  branch condition outcome.

Function
REQ-013 States IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE, out_valid 1 only in DONE.
REQ-014 Accept = in_valid && in_ready; on accept, alu_op, alu_in_1, alu_in_2 SHALL be latched; later input changes have no effect on the operation.
REQ-015 FUNC_ADD/SUB/XOR/OR/AND: IDLE -> DONE on accept; result visible with out_valid the cycle after accept (latency 1); ADD/SUB wrap modulo 2^DATA_WIDTH.
REQ-016 FUNC_BEQ/BNE/BLT/BGE: alu_result = 0; alu_bcond = (A==B)/(A!=B)/(signed A<B)/(signed A>=B); latency 1.
REQ-017 FUNC_LLS/LRS/ARS: IDLE -> SHIFT on accept with nonzero shamt; SHIFT shifts the working register one bit per cycle and decrements a counter; -> DONE when counter reaches 0; latency = shamt+1 cycles.
REQ-018 Shift with shamt 0 SHALL go IDLE -> DONE with result = A, latency 1.
REQ-019 LRS fills with 0, LLS fills LSB with 0, ARS fills MSB with A's original sign bit.
REQ-020 Non-branch ops SHALL drive alu_bcond = 0.
REQ-021 Undefined alu_op codes SHALL complete with latency 1, alu_result = 0, alu_bcond = 0.
REQ-022 alu_result and alu_bcond SHALL be stable while out_valid is 1 and out_ready is 0.
REQ-023 DONE with out_ready = 1 SHALL transition to IDLE next cycle; a new request is accepted no earlier than the cycle after that (no overlap).
REQ-024 in_valid while busy SHALL be ignored (not queued); requester holds in_valid until in_ready.

Reset
REQ-025 reset low SHALL immediately force state IDLE, in_ready = 1 after release, out_valid = 0, alu_result = 0, alu_bcond = 0, shift counter = 0.
REQ-026 reset asserted mid-SHIFT or in DONE SHALL abandon the operation; no result is produced after release.

Configuration
REQ-027 Macro MULTICYCLE_ALU_BARREL_SHIFT_EN defined: shifts use a single-cycle barrel shifter, SHIFT state is unused, all ops have latency 1.
REQ-028 Macro undefined: shifts are iterative per REQ-017/018; all other behaviour identical.

Verification
REQ-029 FUNC_ADD A=32'hFFFF_FFFF, B=1 -> out_valid one cycle after accept, alu_result=0, alu_bcond=0.
REQ-030 FUNC_ARS A=32'h8000_0000, B=4 -> alu_result=32'hF800_0000 after 5 cycles (1 cycle with BARREL_SHIFT_EN); in_ready=0 throughout.
REQ-031 FUNC_BLT A=32'hFFFF_FFFF, B=0 -> alu_bcond=1, alu_result=0; FUNC_BGE same operands -> alu_bcond=0.
REQ-032 FUNC_LRS A=32'h0000_00F0, B=0 -> alu_result=32'h0000_00F0, latency 1.
REQ-033 out_ready held 0 for 3 cycles after FUNC_XOR A=32'hAAAA_AAAA, B=32'hFFFF_FFFF -> alu_result=32'h5555_5555 stable, out_valid=1 all 3 cycles; IDLE one cycle after out_ready=1.
REQ-034 reset asserted during FUNC_LLS B=31 at cycle 10 -> out_valid=0 immediately, outputs 0, in_ready=1 after release, no stale result.

Source files
------------

// File: rtl/multicycle_alu.sv
// multicycle_alu: ALU whose shifts run iteratively, one bit per cycle.
// Define MULTICYCLE_ALU_BARREL_SHIFT_EN for single-cycle barrel shifts.
module multicycle_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_in_1,
  input  logic [DATA_WIDTH-1:0] alu_in_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  alu_bcond
);

  localparam int SW = $clog2(DATA_WIDTH);

  localparam logic [3:0] FUNC_ADD = 4'b0000;
  localparam logic [3:0] FUNC_SUB = 4'b1000;
  localparam logic [3:0] FUNC_LLS = 4'b0001;
  localparam logic [3:0] FUNC_XOR = 4'b0100;
  localparam logic [3:0] FUNC_LRS = 4'b0101;
  localparam logic [3:0] FUNC_ARS = 4'b1101;
  localparam logic [3:0] FUNC_OR  = 4'b0110;
  localparam logic [3:0] FUNC_AND = 4'b0111;
  localparam logic [3:0] FUNC_BEQ = 4'b0010;
  localparam logic [3:0] FUNC_BNE = 4'b0011;
  localparam logic [3:0] FUNC_BLT = 4'b1010;
  localparam logic [3:0] FUNC_BGE = 4'b1011;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] res_q, res_nx;
  logic                  bcond_q, bcond_nx;
  logic [SW-1:0]         cnt_q;
  logic [3:0]            op_q;
  logic                  sign_q;
  logic [SW-1:0]         shamt;
  logic                  is_shift;
  logic                  go_shift;
  logic                  accept;

  assign shamt  = alu_in_2[SW-1:0];
  assign accept = in_valid && in_ready;
  assign is_shift = (alu_op == FUNC_LLS) ||
                    (alu_op == FUNC_LRS) ||
                    (alu_op == FUNC_ARS);
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
  assign go_shift = 1'b0;
`else
  assign go_shift = is_shift && (shamt != '0);
`endif

  // Result captured at accept; for iterative shifts this seeds the work reg.
  always_comb begin
    res_nx   = '0;
    bcond_nx = 1'b0;
    case (alu_op)
      FUNC_ADD: res_nx = alu_in_1 + alu_in_2;
      FUNC_SUB: res_nx = alu_in_1 - alu_in_2;
      FUNC_XOR: res_nx = alu_in_1 ^ alu_in_2;
      FUNC_OR:  res_nx = alu_in_1 | alu_in_2;
      FUNC_AND: res_nx = alu_in_1 & alu_in_2;
      FUNC_BEQ: bcond_nx = (alu_in_1 == alu_in_2);
      FUNC_BNE: bcond_nx = (alu_in_1 != alu_in_2);
      FUNC_BLT: bcond_nx = ($signed(alu_in_1) < $signed(alu_in_2));
      FUNC_BGE: bcond_nx = ($signed(alu_in_1) >= $signed(alu_in_2));
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
      FUNC_LLS: res_nx = alu_in_1 << shamt;
      FUNC_LRS: res_nx = alu_in_1 >> shamt;
      FUNC_ARS: res_nx = $signed(alu_in_1) >>> shamt;
`else
      FUNC_LLS: res_nx = alu_in_1;
      FUNC_LRS: res_nx = alu_in_1;
      FUNC_ARS: res_nx = alu_in_1;
`endif
      default: begin
        res_nx   = '0;
        bcond_nx = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = go_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt_q == SW'(1)) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch on accept, then shift one bit per SHIFT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q   <= '0;
      bcond_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
    end else if (accept) begin
      res_q   <= res_nx;
      bcond_q <= bcond_nx;
      op_q    <= alu_op;
      sign_q  <= alu_in_1[DATA_WIDTH-1];
      cnt_q   <= go_shift ? shamt : '0;
    end else if (state == SHIFT) begin
      cnt_q <= cnt_q - SW'(1);
      case (op_q)
        FUNC_LLS: res_q <= {res_q[DATA_WIDTH-2:0], 1'b0};
        FUNC_LRS: res_q <= {1'b0, res_q[DATA_WIDTH-1:1]};
        FUNC_ARS: res_q <= {sign_q, res_q[DATA_WIDTH-1:1]};
        default:  res_q <= res_q;
      endcase
    end
  end

  assign alu_result = res_q;
  assign alu_bcond  = bcond_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: scoreboard bench with random ops and a reference model.
// Honours MULTICYCLE_ALU_BARREL_SHIFT_EN for expected shift latency.
module tb_multicycle_alu;
  localparam int W = 32;

  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b1000;
  localparam logic [3:0] LLS = 4'b0001;
  localparam logic [3:0] XOR = 4'b0100;
  localparam logic [3:0] LRS = 4'b0101;
  localparam logic [3:0] ARS = 4'b1101;
  localparam logic [3:0] OR  = 4'b0110;
  localparam logic [3:0] AND = 4'b0111;
  localparam logic [3:0] BEQ = 4'b0010;
  localparam logic [3:0] BNE = 4'b0011;
  localparam logic [3:0] BLT = 4'b1010;
  localparam logic [3:0] BGE = 4'b1011;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   alu_op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] alu_result;
  logic         alu_bcond;

  multicycle_alu #(.DATA_WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_op(alu_op),
    .alu_in_1(a),
    .alu_in_2(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_result(alu_result),
    .alu_bcond(alu_bcond)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         bc;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   pass_n = 0;
  int   total_n = 0;
  int   rdy_mode = 0;
  bit   head_seen = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    total_n++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic void model(input logic [3:0] op, input logic [W-1:0] x,
                                input logic [W-1:0] y, output logic [W-1:0] r,
                                output logic bc, output int lat);
    int s;
    s   = int'(y[4:0]);
    r   = '0;
    bc  = 1'b0;
    lat = 1;
    case (op)
      ADD: r = x + y;
      SUB: r = x - y;
      XOR: r = x ^ y;
      OR:  r = x | y;
      AND: r = x & y;
      BEQ: bc = (x == y);
      BNE: bc = (x != y);
      BLT: bc = ($signed(x) < $signed(y));
      BGE: bc = ($signed(x) >= $signed(y));
      LLS: r = x << s;
      LRS: r = x >> s;
      ARS: r = $signed(x) >>> s;
      default: r = '0;
    endcase
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
    if (op == LLS || op == LRS || op == ARS) lat = s + 1;
`endif
  endfunction

  // out_ready driver, changes just after the active edge
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // monitor: compares the head of the scoreboard while out_valid is high
  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("in_ready_vs_busy", {63'd0, in_ready}, {63'd0, q.size() == 0});
      if (out_valid) begin
        if (q.size() == 0) begin
          fail_now("unexpected_out_valid");
        end else begin
          chk("result", {32'd0, alu_result}, {32'd0, q[0].res});
          chk("bcond", {63'd0, alu_bcond}, {63'd0, q[0].bc});
          if (!head_seen)
            chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat - 1));
          head_seen = 1;
          if (out_ready) begin
            void'(q.pop_front());
            head_seen = 0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    alu_op = op;
    a = x;
    b = y;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model(op, x, y, e.res, e.bc, e.lat);
    e.acc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
    alu_op = 4'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] op;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", {32'd0, alu_result}, 64'd0);
    chk("rst_bcond", {63'd0, alu_bcond}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b1;

    issue(ADD, 32'hFFFF_FFFF, 32'h1);
    drain();

    rdy_mode = 1;
    issue(XOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_result", {32'd0, alu_result}, 64'h5555_5555);
    end
    rdy_mode = 2;
    @(negedge clk);
    @(negedge clk);
    chk("idle_after_ready", {63'd0, in_ready}, 64'd1);
    rdy_mode = 0;

    issue(BLT, 32'hFFFF_FFFF, 32'h0);
    issue(BGE, 32'hFFFF_FFFF, 32'h0);
    issue(ARS, 32'h8000_0000, 32'h4);
    issue(LRS, 32'h0000_00F0, 32'h0);
    issue(LLS, 32'h0000_0001, 32'd31);
    issue(ARS, 32'h8000_0001, 32'd31);
    issue(SUB, 32'h0, 32'h1);
    drain();

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom);
      issue(op, $urandom, $urandom);
    end
    drain();

    issue(LLS, $urandom, 32'd31);
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_result", {32'd0, alu_result}, 64'd0);
    chk("mid_rst_bcond", {63'd0, alu_bcond}, 64'd0);
    q.delete();
    head_seen = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("no_stale_result", {63'd0, out_valid}, 64'd0);
    end

    issue(AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
    drain();

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
